// File: rtl/fifo_wr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arb
// Brief    : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ valid/ready producers. Optional per-producer transfer
//            counters when FIFO_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         xfer_cnt
`endif
);

    localparam int c_idx_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(MAX_BURST - 1);
    localparam logic [c_idx_w:0]   c_num_req = NUM_REQ[c_idx_w:0];
    localparam logic [c_idx_w-1:0] c_top_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_one     = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        c_idle  = 1'b0,
        c_burst = 1'b1
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [c_idx_w-1:0]   r_gnt_idx;
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [c_cnt_w-1:0]   r_burst_cnt;

    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [c_idx_w-1:0]   w_gnt_idx_nxt;
    logic [c_idx_w-1:0]   w_rr_ptr_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    logic [2*NUM_REQ-1:0] w_dbl_shift;
    logic [NUM_REQ-1:0]   w_rot;
    logic [c_idx_w-1:0]   w_off;
    logic                 w_any;
    logic [c_idx_w:0]     w_sum;
    logic [c_idx_w:0]     w_wrap;
    logic [c_idx_w-1:0]   w_sel;
    logic [c_idx_w-1:0]   w_release_ptr;
    logic                 w_gvalid;
    logic [DATA_WIDTH-1:0] w_din;

    // Rotate the request vector so bit 0 is the current highest-priority
    // producer; the lowest set bit of the rotated vector is the winner.
    assign w_dbl_shift = {req_valid, req_valid} >> r_rr_ptr;
    assign w_rot       = w_dbl_shift[NUM_REQ-1:0];

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_idx_w'(k);
                w_any = 1'b1;
            end
        end
    end

    assign w_sum         = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_wrap        = (w_sum >= c_num_req) ? (w_sum - c_num_req) : w_sum;
    assign w_sel         = w_wrap[c_idx_w-1:0];
    assign w_release_ptr = (r_gnt_idx == c_top_idx) ? '0 : r_gnt_idx + 1'b1;

    // r_gnt is all-zero outside BURST, so these are naturally inactive in IDLE.
    assign w_gvalid = |(req_valid & r_gnt);

    always_comb begin
        w_din = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_gnt[k]) begin
                w_din = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy       = (r_state == c_burst);
    assign gnt        = r_gnt;
    assign req_ready  = fifo_full ? '0 : r_gnt;
    assign fifo_wr_en = busy & w_gvalid & ~fifo_full;
    assign fifo_din   = w_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_cnt_nxt     = r_burst_cnt;
        case (r_state)
            c_idle: begin
                if (w_any) begin
                    w_state_nxt   = c_burst;
                    w_gnt_nxt     = c_one << w_sel;
                    w_gnt_idx_nxt = w_sel;
                    w_cnt_nxt     = '0;
                end
            end
            c_burst: begin
                // A dropped valid releases without a transfer; a fifo_full
                // stall falls through with the grant and count untouched.
                if (!w_gvalid || (fifo_wr_en && (r_burst_cnt == c_last))) begin
                    w_state_nxt  = c_idle;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_release_ptr;
                end else if (fifo_wr_en) begin
                    w_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (fifo_wr_en && r_gnt[i] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign xfer_cnt[i*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_no_wr_full:  assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));
    a_ready_one:   assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule
`default_nettype wire
